// File: rtl/fetch_prefetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_types: shared types for the instruction-fetch prefetch front end.
//   fetch_state_t    - fetch FSM encoding (FETCH / WAIT / DRAIN)
//   fetch_entry_t    - default queue entry {instr, pc} for a 32-bit core
//   RESET_PC_DEFAULT - default fetch PC after reset
// -----------------------------------------------------------------------------
package fetch_types;

    localparam int          FETCH_XLEN       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue: synchronous FIFO of fetch entries with flush.
//   clk, rst  - clock, asynchronous active-high reset
//   i_push    - write i_data at the tail (ignored when full)
//   i_pop     - drop the head entry (ignored when empty)
//   i_flush   - empty the queue; wins over push and pop
//   o_count   - number of valid entries (0..DEPTH)
//   o_head    - head entry, all zeros when empty
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_types::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  entry_t                 i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output entry_t                 o_head
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Qualify push/pop against the current fill level.
    always_comb begin
        w_do_push = i_push && (r_count != FULL) && !i_flush;
        w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observable through a valid count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Head presentation, forced to zero when empty.
    always_comb begin
        o_count = r_count;
        if (r_count != '0) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit: instruction-fetch front end with a DEPTH-entry
// prefetch queue, one outstanding I-mem request and EX redirect support.
//   clk, rst                  - clock, asynchronous active-high reset
//   redirect, redirect_pc     - EX PC change (low 2 bits ignored)
//   imem_read, imem_address   - I-mem request (address word aligned)
//   imem_resp, imem_rdata     - I-mem one-cycle response pulse and data
//   out_valid, out_ready      - decode handshake
//   out_instr, out_pc         - queue head (zero when nothing valid)
// Optional feature macro FETCH_BYPASS_EN: when the queue is empty an accepted
// response is presented to decode in the same cycle (zero-cycle latency) and
// is only queued if decode does not take it.
// -----------------------------------------------------------------------------
module fetch_prefetch_unit
    import fetch_types::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_read,
    output logic [XLEN-1:0] imem_address,
    input  logic            imem_resp,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] r_stale_addr;
    logic [XLEN-1:0] w_next_stale;
    logic            r_started;
    logic            w_imem_read;
    logic [XLEN-1:0] w_imem_addr;
    logic            w_resp_ok;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    entry_t          w_head;
    entry_t          w_push_data;
    logic [XLEN-1:0] w_redirect_aligned;
    logic [1:0]      w_unused_rpc_bits;

    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_rpc_bits  = redirect_pc[1:0];
    assign w_push_data        = '{instr: imem_rdata, pc: r_fetch_pc};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Fetch FSM next state, request outputs and stale-address capture.
    // r_started holds off the first request for one cycle after reset so a
    // response belonging to an abandoned pre-reset request is never accepted.
    always_comb begin
        w_next_state = r_state;
        w_imem_read  = 1'b0;
        w_imem_addr  = r_fetch_pc;
        w_next_stale = r_stale_addr;
        case (r_state)
            FETCH: begin
                w_imem_read = r_started && (w_count < FULL);
                if (w_imem_read && !imem_resp) begin
                    if (redirect) begin
                        w_next_state = DRAIN;
                        w_next_stale = r_fetch_pc;
                    end else begin
                        w_next_state = WAIT;
                    end
                end else begin
                    w_next_state = FETCH;
                end
            end
            WAIT: begin
                w_imem_read = 1'b1;
                if (imem_resp) begin
                    w_next_state = FETCH;
                end else if (redirect) begin
                    w_next_state = DRAIN;
                    w_next_stale = r_fetch_pc;
                end else begin
                    w_next_state = WAIT;
                end
            end
            DRAIN: begin
                // Keep the in-flight address stable until its data returns.
                w_imem_read = 1'b1;
                w_imem_addr = r_stale_addr;
                if (imem_resp) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = FETCH;
                w_imem_read  = 1'b0;
            end
        endcase
    end

    // Response acceptance and fetch PC update; redirect has top priority.
    always_comb begin
        w_resp_ok = imem_resp && w_imem_read && (r_state != DRAIN);
        if (redirect) begin
            w_next_pc = w_redirect_aligned;
        end else if (w_resp_ok) begin
            w_next_pc = r_fetch_pc + XLEN'(4);
        end else begin
            w_next_pc = r_fetch_pc;
        end
    end

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    // Queue control and decode presentation with same-cycle bypass.
    always_comb begin
        w_bypass = w_resp_ok && !redirect && (w_count == '0);
        w_push   = w_resp_ok && !redirect && !(w_bypass && out_ready);
        w_pop    = (w_count != '0) && out_ready && !redirect;
        if (w_count != '0) begin
            out_valid = 1'b1;
            out_instr = w_head.instr;
            out_pc    = w_head.pc;
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_instr = imem_rdata;
            out_pc    = r_fetch_pc;
        end else begin
            out_valid = 1'b0;
            out_instr = '0;
            out_pc    = '0;
        end
    end
`else
    // Queue control and decode presentation straight from the queue head.
    always_comb begin
        w_push    = w_resp_ok && !redirect;
        w_pop     = (w_count != '0) && out_ready && !redirect;
        out_valid = (w_count != '0);
        out_instr = w_head.instr;
        out_pc    = w_head.pc;
    end
`endif

    assign imem_read    = w_imem_read;
    assign imem_address = w_imem_addr;

    // State, PC and request bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FETCH;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= '0;
            r_started    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_fetch_pc   <= w_next_pc;
            r_stale_addr <= w_next_stale;
            r_started    <= 1'b1;
        end
    end

endmodule
